// File: rtl/dm_store_buffer.sv
// In-order store buffer in front of a single-port data memory.
// Optional: define STBUF_COALESCE_EN to merge stores to a queued address.
module dm_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       LD_REQ,
    input  logic                       ST_REQ,
    input  logic [ADDR_W-1:0]          REQ_ADDR,
    input  logic [DATA_W-1:0]          REQ_WDATA,
    input  logic                       FLUSH,
    output logic                       REQ_STALL,
    output logic                       LD_VALID,
    output logic [DATA_W-1:0]          LD_DATA,
    output logic                       EMPTY,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       DM_READ,
    output logic                       DM_WRT,
    output logic [ADDR_W-1:0]          DM_ADDR,
    output logic [DATA_W-1:0]          DM_DIN,
    input  logic [DATA_W-1:0]          DM_DOUT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q;

    logic              full, match;
    logic [PW-1:0]     match_idx, idx;
    logic [DATA_W-1:0] match_data;
    logic              ld, idle, ld_hit, ld_go, ld_stall;
    logic              st_acc, co_acc, push, drain;

    assign full = (count_q == CW'(DEPTH));

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        match      = 1'b0;
        match_idx  = '0;
        match_data = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q && addr_q[idx] == REQ_ADDR) begin
                match      = 1'b1;
                match_idx  = idx;
                match_data = data_q[idx];
            end
        end
    end

    assign ld       = LD_REQ && !ST_REQ;
    assign idle     = !LD_REQ && !ST_REQ;
    assign ld_hit   = ld && match;
    assign ld_go    = ld && !match && !full && !FLUSH;
    assign ld_stall = ld && !match && (full || FLUSH);

`ifdef STBUF_COALESCE_EN
    assign co_acc = ST_REQ && match && !FLUSH;
    assign st_acc = ST_REQ && !FLUSH && (!full || match);
`else
    assign co_acc = 1'b0;
    assign st_acc = ST_REQ && !full && !FLUSH;
`endif

    assign push = st_acc && !co_acc;

    // Never pop in the cycle a store merges, or the merge could land
    // in the entry that is leaving.
    assign drain = RST_N && (count_q != '0) && !ld_go && !co_acc
                   && (idle || full || FLUSH);

    assign DM_READ   = RST_N && ld_go;
    assign DM_WRT    = drain;
    assign LD_VALID  = RST_N && (ld_hit || ld_go);
    assign REQ_STALL = RST_N && (ld_stall || (ST_REQ && !st_acc));
    assign EMPTY     = (count_q == '0);
    assign COUNT     = count_q;

    always_comb begin
        DM_ADDR = '0;
        DM_DIN  = '0;
        LD_DATA = '0;
        if (DM_READ) begin
            DM_ADDR = REQ_ADDR;
        end else if (DM_WRT) begin
            DM_ADDR = addr_q[head_q];
            DM_DIN  = data_q[head_q];
        end
        if (LD_VALID)
            LD_DATA = ld_hit ? match_data : DM_DOUT;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                addr_q[tail_q] <= REQ_ADDR;
                data_q[tail_q] <= REQ_WDATA;
                tail_q         <= tail_q + 1'b1;
            end
            if (co_acc)
                data_q[match_idx] <= REQ_WDATA;
            if (drain)
                head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(drain);
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed vector bench for dm_store_buffer (DEPTH=4).
module tb_dm_store_buffer;

`ifdef STBUF_COALESCE_EN
    localparam bit CO = 1'b1;
`else
    localparam bit CO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, ld, st, fl;
    logic [31:0] addr, wd, dout;
    logic        stall, lv, emp, rd, wr;
    logic [31:0] ldd, da, dd;
    logic [2:0]  cnt;

    int nerr = 0;
    int nchk = 0;
    int nwr  = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (wr) nwr++;

    dm_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(clk), .RST_N(rst_n), .LD_REQ(ld), .ST_REQ(st),
        .REQ_ADDR(addr), .REQ_WDATA(wd), .FLUSH(fl),
        .REQ_STALL(stall), .LD_VALID(lv), .LD_DATA(ldd),
        .EMPTY(emp), .COUNT(cnt), .DM_READ(rd), .DM_WRT(wr),
        .DM_ADDR(da), .DM_DIN(dd), .DM_DOUT(dout)
    );

    typedef struct {
        logic        rn, ld, st, fl;
        logic [31:0] addr, wd, dout;
        logic        stall, lv;
        logic [31:0] ldd;
        logic        emp;
        logic [2:0]  cnt;
        logic        rd, wr;
        logic [31:0] da, dd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(
        input logic rn_, ld_, st_, fl_,
        input int a_, w_, o_,
        input logic s_, l_, input int ld_d,
        input logic e_, input int c_,
        input logic r_, w2, input int da_, dd_);
        vec_t r;
        r.rn = rn_; r.ld = ld_; r.st = st_; r.fl = fl_;
        r.addr = a_; r.wd = w_; r.dout = o_;
        r.stall = s_; r.lv = l_; r.ldd = ld_d;
        r.emp = e_; r.cnt = 3'(c_);
        r.rd = r_; r.wr = w2; r.da = da_; r.dd = dd_;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rn_, ld_, st_, fl_,
                         input logic [31:0] a_, w_, o_);
        @(posedge clk);
        #1;
        rst_n = rn_; ld = ld_; st = st_; fl = fl_;
        addr = a_; wd = w_; dout = o_;
    endtask

    int w0;

    initial begin
        rst_n = 0; ld = 0; st = 0; fl = 0;
        addr = 0; wd = 0; dout = 0;
        repeat (2) @(posedge clk);

        vt.push_back(v(0,0,0,0, 0,0,0,     0,0,0,  1,0, 0,0,0,0));
        vt.push_back(v(1,0,1,0, 32,100,0,  0,0,0,  1,0, 0,0,0,0));
        vt.push_back(v(1,0,0,0, 0,0,0,     0,0,0,  0,1, 0,1,32,100));
        vt.push_back(v(1,0,0,0, 0,0,0,     0,0,0,  1,0, 0,0,0,0));
        vt.push_back(v(1,0,1,0, 40,7,0,    0,0,0,  1,0, 0,0,0,0));
        vt.push_back(v(1,1,0,0, 40,0,0,    0,1,7,  0,1, 0,0,0,0));
        vt.push_back(v(1,1,0,0, 31,0,555,  0,1,555,0,1, 1,0,31,0));
        vt.push_back(v(1,0,0,0, 0,0,0,     0,0,0,  0,1, 0,1,40,7));
        vt.push_back(v(1,0,0,0, 0,0,0,     0,0,0,  1,0, 0,0,0,0));
        for (int i = 0; i < 4; i++)
            vt.push_back(v(1,0,1,0, 50+i,1+i,0, 0,0,0, i==0,i, 0,0,0,0));
        vt.push_back(v(1,0,1,0, 54,5,0,    1,0,0,  0,4, 0,1,50,1));
        vt.push_back(v(1,0,1,0, 54,5,0,    0,0,0,  0,3, 0,0,0,0));
        vt.push_back(v(1,1,0,0, 52,0,0,    0,1,3,  0,4, 0,1,51,2));
        vt.push_back(v(1,1,0,0, 99,0,77,   0,1,77, 0,3, 1,0,99,0));
        vt.push_back(v(1,1,0,1, 99,0,0,    1,0,0,  0,3, 0,1,52,3));
        vt.push_back(v(1,1,0,1, 99,0,0,    1,0,0,  0,2, 0,1,53,4));
        vt.push_back(v(1,1,0,1, 99,0,0,    1,0,0,  0,1, 0,1,54,5));
        vt.push_back(v(1,1,0,1, 99,0,0,    1,0,0,  1,0, 0,0,0,0));
        vt.push_back(v(1,1,0,0, 99,0,12,   0,1,12, 1,0, 1,0,99,0));
        vt.push_back(v(1,0,1,0, 60,5,0,    0,0,0,  1,0, 0,0,0,0));
        vt.push_back(v(1,0,1,0, 60,9,0,    0,0,0,  0,1, 0,0,0,0));
        vt.push_back(v(1,1,0,0, 60,0,0,    0,1,9,  0,CO?1:2, 0,0,0,0));
        vt.push_back(v(1,0,0,0, 0,0,0,     0,0,0,  0,CO?1:2, 0,1,60,CO?9:5));
        if (CO)
            vt.push_back(v(1,0,0,0, 0,0,0, 0,0,0,  1,0, 0,0,0,0));
        else
            vt.push_back(v(1,0,0,0, 0,0,0, 0,0,0,  0,1, 0,1,60,9));
        vt.push_back(v(1,0,0,0, 0,0,0,     0,0,0,  1,0, 0,0,0,0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rn, vt[i].ld, vt[i].st, vt[i].fl,
                  vt[i].addr, vt[i].wd, vt[i].dout);
            @(negedge clk);
            chk($sformatf("r%0d stall", i), 32'(stall), 32'(vt[i].stall));
            chk($sformatf("r%0d ld_valid", i), 32'(lv), 32'(vt[i].lv));
            chk($sformatf("r%0d ld_data", i), ldd, vt[i].ldd);
            chk($sformatf("r%0d empty", i), 32'(emp), 32'(vt[i].emp));
            chk($sformatf("r%0d count", i), 32'(cnt), 32'(vt[i].cnt));
            chk($sformatf("r%0d dm_read", i), 32'(rd), 32'(vt[i].rd));
            chk($sformatf("r%0d dm_wrt", i), 32'(wr), 32'(vt[i].wr));
            chk($sformatf("r%0d dm_addr", i), da, vt[i].da);
            chk($sformatf("r%0d dm_din", i), dd, vt[i].dd);
        end

        // Reset with two entries queued: no write may escape.
        drive(1, 0, 1, 0, 70, 1, 0);
        drive(1, 0, 1, 0, 71, 2, 0);
        @(negedge clk);
        chk("rst pre count", 32'(cnt), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        w0 = nwr;
        @(negedge clk);
        chk("rst dm_wrt", 32'(wr), 32'd0);
        chk("rst dm_read", 32'(rd), 32'd0);
        chk("rst ld_valid", 32'(lv), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        #1;
        chk("rst no write", 32'(nwr), 32'(w0));
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post rst count", 32'(cnt), 32'd0);
        chk("post rst empty", 32'(emp), 32'd1);
        chk("post rst dm_wrt", 32'(wr), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Store buffer between the memory-stage pipeline logic and the data memory (DM). Stores are queued in a small in-order FIFO and written to DM on idle cycles, so loads get priority on the single DM port; loads that hit a queued store are forwarded from the buffer. The block drives DM's READ/WRT/Address/DataIn and consumes its combinational DataOut.

## Interface
- DEPTH, 4: number of store entries; power of two, ≥2
- ADDR_W, 32: word-address width
- DATA_W, 32: data width

- CLK  input  1  clock; state updates on posedge
- RST_N  input  1  reset, synchronous, active-low
- LD_REQ  input  1  load request this cycle
- ST_REQ  input  1  store request this cycle
- REQ_ADDR  input  ADDR_W  load/store word address
- REQ_WDATA  input  DATA_W  store data
- FLUSH  input  1  drain request; hold high until EMPTY
- REQ_STALL  output  1  request not accepted this cycle; pipeline holds it
- LD_VALID  output  1  LD_DATA valid this cycle
- LD_DATA  output  DATA_W  load result
- EMPTY  output  1  no entries queued
- COUNT  output  $clog2(DEPTH+1)  entries queued
- DM_READ  output  1  to DM READ
- DM_WRT  output  1  to DM WRT
- DM_ADDR  output  ADDR_W  to DM Address
- DM_DIN  output  DATA_W  to DM DataIn
- DM_DOUT  input  DATA_W  from DM DataOut

## Operation
- State: DEPTH entries {addr, data}, head/tail pointers, COUNT; in-order FIFO, pointers wrap modulo DEPTH.
- full = (COUNT == DEPTH); hit = LD_REQ and any queued entry with addr == REQ_ADDR (all ADDR_W bits compared).
- LD_REQ and ST_REQ together is illegal; block services the store, ignores the load (LD_VALID=0).
- Load hit: LD_DATA = data of youngest matching entry, LD_VALID=1, DM_READ=0, REQ_STALL=0. Allowed when full or during FLUSH.
- Load miss granted when !full and !FLUSH: DM_READ=1, DM_ADDR=REQ_ADDR, LD_DATA=DM_DOUT, LD_VALID=1.
- Load miss when full or FLUSH: REQ_STALL=1, LD_VALID=0.
- Store: accepted at posedge when !full and !FLUSH; written at tail. If full or FLUSH: REQ_STALL=1.
- Drain enabled when COUNT>0, no load miss granted, and (no request, or full, or FLUSH). Drain: DM_WRT=1, DM_ADDR/DM_DIN = head entry; DM writes on the negedge; head pops at the following posedge.
- Full + ST_REQ: drain this cycle, store stalled; accepted next cycle (COUNT=DEPTH-1). No simultaneous push and pop when full.
- Not full: push and pop never coincide, because stores are accepted only on non-idle cycles and drains occur only on idle cycles.
- When DM_READ and DM_WRT are both 0, DM_ADDR/DM_DIN are 0. LD_DATA is 0 when LD_VALID=0.
- RST_N low: entries discarded, COUNT=0. DM_WRT, DM_READ, LD_VALID and REQ_STALL are forced to 0 combinationally in the reset cycle, so no DM write occurs at that negedge.

## Timing
- Reset values: COUNT=0, EMPTY=1, all other outputs 0.
- Load hit/miss: zero latency; LD_DATA is combinational in the request cycle.
- A store accepted at the posedge ending cycle N is forwardable from cycle N+1. Its earliest DM write is at the negedge of cycle N+1, if that cycle is idle.
- FLUSH drains one entry per cycle. EMPTY rises the cycle after the last pop.

## Configuration
- STBUF_COALESCE_EN defined: a store whose address matches a queued entry overwrites that entry's data in place. COUNT is unchanged and the store is accepted even when full, unless FLUSH is high.
- Undefined: every store appends a new entry; forwarding selects the youngest match.

## Test plan
- Queue 2 entries, then RST_N low 1 cycle -> COUNT=0, EMPTY=1, DM_WRT=0 throughout, no DM write at that negedge.
- ST addr 32 data 100, then idle -> next cycle DM_WRT=1, DM_ADDR=32, DM_DIN=100; COUNT 1→0.
- ST addr 40 data 7, then LD addr 40 -> LD_VALID=1, LD_DATA=7, DM_READ=0; LD addr 31 (miss) -> DM_READ=1, LD_DATA=DM_DOUT.
- ST to 50..53, data 1..4, on 4 consecutive cycles -> COUNT=4, no DM_WRT. 5th ST addr 54 -> REQ_STALL=1 with DM_WRT=1, addr 50, data 1; accepted the next cycle.
- 3 entries queued, FLUSH high with LD_REQ miss pending -> REQ_STALL=1; 3 consecutive DM writes in FIFO order; EMPTY=1 on the following cycle.
- ST addr 60 data 5, ST addr 60 data 9, LD addr 60 -> LD_DATA=9. With STBUF_COALESCE_EN: COUNT=1, one DM write of 9. Without: COUNT=2, writes 5 then 9.
